pipe_stage_buf: RTL and testbench

- Parametrised pipeline-stage register between any two stages of the RV32I 5-stage core (IF/ID first; reusable for ID/EX, EX/MEM).
- Carries PC, branch-predict bit and a generic payload with valid/ready handshake, flush and optional 2-entry skid buffering.
- Registered in_ready in skid mode, so stall back-pressure does not form a combinational path across stages.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_slot.sv | 42 ++++
 rtl/pipe_stage_buf.sv | 115 +++++++++++
 tb/tb_pipe_stage_buf.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and entry type for the pipeline-stage buffers.
package pipe_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned PAYLOAD_W_DEF = 32;
  localparam logic [31:0] RV_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0]      pc;
    logic                     pred;
    logic [PAYLOAD_W_DEF-1:0] payload;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_slot.sv
// One buffered pipeline entry: valid flag plus data register, synchronous active-low reset.
module pipe_slot #(
  parameter int unsigned Width = 65
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_d, valid_q;
  logic [Width-1:0] data_d, data_q;

  // Clear wins over load; data is left untouched on clear so it can be held.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, flush and optional 2-entry skid buffer.
// Define PIPE_NOP_FILL_EN to drive an architectural NOP on the outputs during bubbles.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned          XLEN        = XLEN_DEF,
  parameter int unsigned          PAYLOAD_W   = 32,
  parameter bit                   SKID        = 1'b1,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = RV_NOP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 in_pred,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic                 out_pred,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy
);

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic                 pred;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  localparam int unsigned EntryW = $bits(entry_t);

  entry_t in_entry, main_din, main_data;
  logic   main_valid, main_load, main_clr;
  logic   skid_valid;
  logic   accept, pop;

  assign in_entry = '{pc: in_pc, pred: in_pred, payload: in_payload};
  assign accept   = in_valid && in_ready;
  assign pop      = main_valid && out_ready;

  pipe_slot #(
    .Width (EntryW)
  ) u_main (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (main_load),
    .clr_i   (main_clr),
    .data_i  (main_din),
    .valid_o (main_valid),
    .data_o  (main_data)
  );

  if (SKID) begin : g_skid
    entry_t skid_data;
    logic   skid_load, skid_clr;

    pipe_slot #(
      .Width (EntryW)
    ) u_skid (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .load_i  (skid_load),
      .clr_i   (skid_clr),
      .data_i  (in_entry),
      .valid_o (skid_valid),
      .data_o  (skid_data)
    );

    // in_ready is a flop output; skid is only ever filled while main is held.
    assign in_ready = !skid_valid;

    always_comb begin
      main_din  = skid_valid ? skid_data : in_entry;
      main_load = (pop && skid_valid) || (accept && (!main_valid || pop));
      main_clr  = flush || (pop && !skid_valid && !accept);
      skid_load = accept && main_valid && !pop;
      skid_clr  = flush || (pop && skid_valid);
    end
  end else begin : g_single
    assign skid_valid = 1'b0;
    assign in_ready   = !main_valid || out_ready;

    always_comb begin
      main_din  = in_entry;
      main_load = accept;
      main_clr  = flush || (pop && !accept);
    end
  end

  assign out_valid = main_valid;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

`ifdef PIPE_NOP_FILL_EN
  always_comb begin
    out_pc      = '0;
    out_pred    = 1'b0;
    out_payload = NOP_PAYLOAD;
    if (main_valid) begin
      out_pc      = main_data.pc;
      out_pred    = main_data.pred;
      out_payload = main_data.payload;
    end
  end
`else
  logic unused_nop;
  assign unused_nop  = ^NOP_PAYLOAD;
  assign out_pc      = main_data.pc;
  assign out_pred    = main_data.pred;
  assign out_payload = main_data.payload;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench: a SKID=1 and a SKID=0 instance share stimulus; each has a queue model.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_pred, out_ready;
  logic [31:0] in_pc, in_payload;

  logic        a_in_ready, a_out_valid, a_out_pred;
  logic [31:0] a_out_pc, a_out_payload;
  logic [1:0]  a_occ;
  logic        b_in_ready, b_out_valid, b_out_pred;
  logic [31:0] b_out_pc, b_out_payload;
  logic [1:0]  b_occ;

  int checks   = 0;
  int failures = 0;

  logic [64:0] qa[$];
  logic [64:0] qb[$];
  logic [64:0] hold_a, hold_b;
  logic [31:0] popped_a[$];
  bit          known   = 1'b0;
  bit          acc_a   = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.XLEN(32), .PAYLOAD_W(32), .SKID(1'b1)) dut_a (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (a_in_ready), .in_pc (in_pc), .in_pred (in_pred),
    .in_payload (in_payload), .out_valid (a_out_valid), .out_ready (out_ready),
    .out_pc (a_out_pc), .out_pred (a_out_pred), .out_payload (a_out_payload),
    .occupancy (a_occ)
  );

  pipe_stage_buf #(.XLEN(32), .PAYLOAD_W(32), .SKID(1'b0)) dut_b (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (b_in_ready), .in_pc (in_pc), .in_pred (in_pred),
    .in_payload (in_payload), .out_valid (b_out_valid), .out_ready (out_ready),
    .out_pc (b_out_pc), .out_pred (b_out_pred), .out_payload (b_out_payload),
    .occupancy (b_occ)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected data outputs: head when non-empty, otherwise bubble value.
  function automatic logic [64:0] bubble(input logic [64:0] hold);
`ifdef PIPE_NOP_FILL_EN
    return {32'h0, 1'b0, 32'h0000_0013};
`else
    return hold;
`endif
  endfunction

  task automatic chk_dut(input string n, input int sz, input logic [64:0] head,
                         input logic [64:0] hold, input logic exp_ir,
                         input logic ov, input logic [1:0] occ, input logic [31:0] opc,
                         input logic opr, input logic [31:0] opl, input logic ir);
    logic [64:0] e;
    e = (sz > 0) ? head : bubble(hold);
    chk({n, "_out_valid"}, 64'(ov), 64'(sz > 0));
    chk({n, "_occupancy"}, 64'(occ), 64'(sz));
    chk({n, "_in_ready"}, 64'(ir), 64'(exp_ir));
    chk({n, "_out_pc"}, 64'(opc), 64'(e[64:33]));
    chk({n, "_out_pred"}, 64'(opr), 64'(e[32]));
    chk({n, "_out_payload"}, 64'(opl), 64'(e[31:0]));
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic pr,
                      input logic [31:0] pl, input logic ordy, input logic fl,
                      input logic rn);
    logic        rdy_a, rdy_b, pop;
    logic [64:0] beat;
    @(negedge clk);
    in_valid = v; in_pc = pc; in_pred = pr; in_payload = pl;
    out_ready = ordy; flush = fl; rst_n = rn;
    rdy_a = qa.size() < 2;
    rdy_b = (qb.size() == 0) || ordy;
    #1;
    if (known) begin
      chk_dut("a", qa.size(), (qa.size() > 0) ? qa[0] : 65'h0, hold_a, rdy_a,
              a_out_valid, a_occ, a_out_pc, a_out_pred, a_out_payload, a_in_ready);
      chk_dut("b", qb.size(), (qb.size() > 0) ? qb[0] : 65'h0, hold_b, rdy_b,
              b_out_valid, b_occ, b_out_pc, b_out_pred, b_out_payload, b_in_ready);
    end
    @(posedge clk);
    beat  = {pc, pr, pl};
    acc_a = 1'b0;
    if (!rn) begin
      qa.delete(); qb.delete();
      hold_a = '0; hold_b = '0;
      known  = 1'b1;
    end else if (known) begin
      pop   = (qa.size() > 0) && ordy;
      acc_a = v && rdy_a && !fl;
      if (pop) popped_a.push_back(qa[0][64:33]);
      if (fl) qa.delete();
      else begin
        if (pop) void'(qa.pop_front());
        if (acc_a) qa.push_back(beat);
      end
      pop = (qb.size() > 0) && ordy;
      if (fl) qb.delete();
      else begin
        if (pop) void'(qb.pop_front());
        if (v && rdy_b) qb.push_back(beat);
      end
      if (qa.size() > 0) hold_a = qa[0];
      if (qb.size() > 0) hold_b = qb[0];
    end
  endtask

  initial begin
    int idx;
    logic [31:0] pc;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pred = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_payload = '0;

    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h99, 1, 32'h1234, 1, 0, 0);

    // Stream three beats at full rate.
    step(1, 32'h00, 0, 32'hA000, 1, 0, 1);
    step(1, 32'h04, 0, 32'hA004, 1, 0, 1);
    step(1, 32'h08, 0, 32'hA008, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);

    // Stall: upstream holds 0x18 until accepted by the skid instance.
    popped_a.delete();
    step(1, 32'h10, 0, 32'hB010, 0, 0, 1);
    step(1, 32'h14, 0, 32'hB014, 0, 0, 1);
    step(1, 32'h18, 0, 32'hB018, 0, 0, 1);
    idx = 0;
    while (!acc_a && idx < 10) begin
      step(1, 32'h18, 0, 32'hB018, 1, 0, 1);
      idx++;
    end
    repeat (3) step(0, 0, 0, 0, 1, 0, 1);
    chk("stall_order_len", 64'(popped_a.size()), 64'd3);
    if (popped_a.size() == 3) begin
      chk("stall_order_0", 64'(popped_a[0]), 64'h10);
      chk("stall_order_1", 64'(popped_a[1]), 64'h14);
      chk("stall_order_2", 64'(popped_a[2]), 64'h18);
    end

    // Flush while full with an incoming beat.
    popped_a.delete();
    step(1, 32'h30, 0, 32'hC030, 0, 0, 1);
    step(1, 32'h34, 0, 32'hC034, 0, 0, 1);
    step(1, 32'h20, 0, 32'hC020, 0, 1, 1);
    repeat (3) step(0, 0, 0, 0, 1, 0, 1);
    chk("flush_no_pops", 64'(popped_a.size()), 64'd0);

    // Prediction bit tracks its own beat only.
    step(1, 32'h3C, 0, 32'hD03C, 1, 0, 1);
    step(1, 32'h40, 1, 32'hD040, 1, 0, 1);
    step(1, 32'h44, 0, 32'hD044, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);

    // Bubble after 0x50.
    step(1, 32'h50, 1, 32'hE050, 1, 0, 1);
    repeat (3) step(0, 0, 0, 0, 1, 0, 1);

    // Reset in the middle of a stall.
    step(1, 32'h60, 1, 32'hF060, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Randomised traffic, checking ordering of accepted beats end to end.
    pc = 32'h100;
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), pc, 1'($urandom), $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 63) != 0));
      if (acc_a) pc = pc + 32'd4;
    end
    repeat (4) step(0, 0, 0, 0, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
